// File: rtl/wt_dcache_shct_ctrl.sv
// SHiP SHCT sequencer: one table op per cycle; lookups finish in 1 cycle, hit/miss ops as read-modify-write over 2-3 cycles.
// Ungranted requests wait, and grants stop during clear and mid-op. Define WT_DCACHE_SHCT_STATS_EN to add the stat_*_o counters.
module wt_dcache_shct_ctrl #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned SigWidth = 14,
  parameter int unsigned CntWidth = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  output logic                               busy_o,
  input  logic                               pred_req_i,
  input  logic [SigWidth-1:0]                pred_sig_i,
  output logic                               pred_gnt_o,
  output logic                               pred_valid_o,
  output logic                               pred_result_o,
  input  logic [NumPorts-1:0]                hit_req_i,
  input  logic [NumPorts-1:0][SigWidth-1:0]  hit_sig_i,
  output logic [NumPorts-1:0]                hit_gnt_o,
  input  logic                               miss_req_i,
  input  logic [SigWidth-1:0]                miss_evict_sig_i,
  input  logic                               miss_evict_reused_i,
  input  logic [SigWidth-1:0]                miss_new_sig_i,
  output logic                               miss_gnt_o,
  output logic                               tbl_req_o,
  output logic                               tbl_we_o,
  output logic [SigWidth-1:0]                tbl_addr_o,
  output logic [CntWidth-1:0]                tbl_wdata_o,
`ifdef WT_DCACHE_SHCT_STATS_EN
  output logic [31:0]                        stat_hit_o,
  output logic [31:0]                        stat_dec_o,
  output logic [31:0]                        stat_sat_o,
`endif
  input  logic [CntWidth-1:0]                tbl_rdata_i
);

  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic [2:0] {CLEAR, IDLE, HIT_WR, MISS_DEC, MISS_INIT} state_e;

  state_e              state_q, state_d;
  logic [SigWidth-1:0] clr_addr_q, clr_addr_d;
  logic [SigWidth-1:0] sig_q, sig_d;
  logic [SigWidth-1:0] new_sig_q, new_sig_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                pred_valid_q;
  logic                hit_any;
  logic [PtrW-1:0]     hit_idx, hit_nxt;
  logic [CntWidth-1:0] cnt_inc, cnt_dec;

  // Round-robin: ports at or above rr_ptr win over those below it.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int p = NumPorts-1; p >= 0; p--) begin
      if (hit_req_i[p] && (PtrW'(p) < rr_ptr_q)) begin
        hit_any = 1'b1;
        hit_idx = PtrW'(p);
      end
    end
    for (int p = NumPorts-1; p >= 0; p--) begin
      if (hit_req_i[p] && (PtrW'(p) >= rr_ptr_q)) begin
        hit_any = 1'b1;
        hit_idx = PtrW'(p);
      end
    end
    hit_nxt = (hit_idx == PtrW'(NumPorts-1)) ? '0 : hit_idx + PtrW'(1);
  end

  assign cnt_inc = (tbl_rdata_i == CntMax) ? tbl_rdata_i : tbl_rdata_i + CntWidth'(1);
  assign cnt_dec = (tbl_rdata_i == '0)     ? tbl_rdata_i : tbl_rdata_i - CntWidth'(1);

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    sig_d       = sig_q;
    new_sig_d   = new_sig_q;
    rr_ptr_d    = rr_ptr_q;
    busy_o      = 1'b0;
    pred_gnt_o  = 1'b0;
    hit_gnt_o   = '0;
    miss_gnt_o  = 1'b0;
    tbl_req_o   = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_addr_o  = '0;
    tbl_wdata_o = '0;
    unique case (state_q)
      CLEAR: begin
        busy_o     = 1'b1;
        tbl_req_o  = 1'b1;
        tbl_we_o   = 1'b1;
        tbl_addr_o = clr_addr_q;
        clr_addr_d = clr_addr_q + SigWidth'(1);
        if (clr_addr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (pred_req_i) begin
          pred_gnt_o = 1'b1;
          tbl_req_o  = 1'b1;
          tbl_addr_o = pred_sig_i;
        end else if (miss_req_i) begin
          miss_gnt_o = 1'b1;
          sig_d      = miss_evict_sig_i;
          new_sig_d  = miss_new_sig_i;
          if (!miss_evict_reused_i) begin
            tbl_req_o  = 1'b1;
            tbl_addr_o = miss_evict_sig_i;
            state_d    = MISS_DEC;
          end else begin
            state_d = MISS_INIT;
          end
        end else if (hit_any) begin
          hit_gnt_o  = NumPorts'(1) << hit_idx;
          sig_d      = hit_sig_i[hit_idx];
          rr_ptr_d   = hit_nxt;
          tbl_req_o  = 1'b1;
          tbl_addr_o = hit_sig_i[hit_idx];
          state_d    = HIT_WR;
        end
      end
      HIT_WR: begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = sig_q;
        tbl_wdata_o = cnt_inc;
        state_d     = IDLE;
      end
      MISS_DEC: begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = sig_q;
        tbl_wdata_o = cnt_dec;
        state_d     = MISS_INIT;
      end
      MISS_INIT: begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = new_sig_q;
        state_d     = IDLE;
      end
      default: state_d = CLEAR;
    endcase
    // Flush kills whatever this cycle would have done, including grants.
    if (flush_i) begin
      state_d     = CLEAR;
      clr_addr_d  = '0;
      rr_ptr_d    = rr_ptr_q;
      pred_gnt_o  = 1'b0;
      hit_gnt_o   = '0;
      miss_gnt_o  = 1'b0;
      tbl_req_o   = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = '0;
      tbl_wdata_o = '0;
    end
    if (!rst_ni) begin
      busy_o      = 1'b1;
      pred_gnt_o  = 1'b0;
      hit_gnt_o   = '0;
      miss_gnt_o  = 1'b0;
      tbl_req_o   = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = '0;
      tbl_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      sig_q        <= '0;
      new_sig_q    <= '0;
      rr_ptr_q     <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      sig_q        <= sig_d;
      new_sig_q    <= new_sig_d;
      rr_ptr_q     <= rr_ptr_d;
      pred_valid_q <= pred_gnt_o;
    end
  end

  assign pred_valid_o  = pred_valid_q & rst_ni;
  assign pred_result_o = pred_valid_o & (tbl_rdata_i != '0);

`ifdef WT_DCACHE_SHCT_STATS_EN
  logic [31:0] stat_hit_q, stat_dec_q, stat_sat_q;
  logic        sat_wr;

  assign sat_wr = !flush_i && (((state_q == HIT_WR) && (tbl_rdata_i == CntMax)) ||
                               ((state_q == MISS_DEC) && (tbl_rdata_i == '0)));

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_hit_q <= '0;
      stat_dec_q <= '0;
      stat_sat_q <= '0;
    end else begin
      if (!flush_i && (state_q == HIT_WR))   stat_hit_q <= stat_hit_q + 32'd1;
      if (!flush_i && (state_q == MISS_DEC)) stat_dec_q <= stat_dec_q + 32'd1;
      if (sat_wr)                            stat_sat_q <= stat_sat_q + 32'd1;
    end
  end

  assign stat_hit_o = stat_hit_q;
  assign stat_dec_o = stat_dec_q;
  assign stat_sat_o = stat_sat_q;
`endif

endmodule
